// File: rtl/regfile_pkg.sv
// Shared defaults and select-width helper for the parametrised register file.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_NREGS = 8;

  // Width needed to select any of n registers; at least one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_bypass_decoder.sv
// Enable-gated one-hot decoder for N outputs; selects at or above N decode to zero.
module decoder_n #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic [AW-1:0] Addr,
  input  logic          We,
  output logic [N-1:0]  Out
);

  for (genvar gi = 0; gi < N; gi++) begin : g_out
    assign Out[gi] = We && (Addr == AW'(gi));
  end

endmodule

// File: rtl/regfile_bypass.sv
// Register file with one write port, two combinational read ports, optional
// same-cycle write forwarding, optional hard-wired zero r0 and a sticky error flag.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NREGS   = DEFAULT_NREGS,
  parameter int ADDR_W  = addr_w(NREGS),
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1RegSel,
  input  logic [ADDR_W-1:0] read2RegSel,
  input  logic [ADDR_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              write,
  output logic [WIDTH-1:0]  read1Data,
  output logic [WIDTH-1:0]  read2Data,
  output logic              err
);

  // One extra bit so NREGS itself is representable when it is a power of two.
  localparam logic [ADDR_W:0] NREGS_CMP = (ADDR_W + 1)'(NREGS);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]            dec_out;
  logic [NREGS-1:0]            wr_en;
  logic                        err_q, err_d;
  logic                        wr_in_range;
  logic                        wr_oob;

  assign wr_in_range = {1'b0, writeRegSel} < NREGS_CMP;
  assign wr_oob      = write && !wr_in_range;

  decoder_n #(
    .N  (NREGS),
    .AW (ADDR_W)
  ) u_dec (
    .Addr (writeRegSel),
    .We   (write),
    .Out  (dec_out)
  );

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (ZERO_R0 && gi == 0) begin : g_zero
      assign wr_en[gi] = 1'b0;
    end else begin : g_norm
      assign wr_en[gi] = dec_out[gi];
    end
    assign regs_d[gi] = wr_en[gi] ? writeData : regs_q[gi];
  end

  assign err_d = err_q | wr_oob;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      err_q  <= err_d;
    end
  end

  logic [1:0][ADDR_W-1:0] rd_sel;
  assign rd_sel = {read2RegSel, read1RegSel};

  // Independent mux per read port; forwarding is evaluated per port.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [WIDTH-1:0] data;
    logic             in_range;
    assign in_range = {1'b0, rd_sel[gi]} < NREGS_CMP;

    always_comb begin
      data = '0;
      if (in_range) begin
        data = regs_q[rd_sel[gi]];
        if (BYPASS && write && wr_in_range && (rd_sel[gi] == writeRegSel)) begin
          data = writeData;
        end
      end
      if (ZERO_R0 && rd_sel[gi] == '0) begin
        data = '0;
      end
    end
  end

  assign read1Data = g_rd[0].data;
  assign read2Data = g_rd[1].data;
  assign err       = err_q;

endmodule

// File: tb/tb_regfile_bypass.sv
// Drives two register-file configurations with shared stimulus and checks them against a model.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  read1RegSel, read2RegSel, writeRegSel;
  logic [15:0] writeData;
  logic        write;

  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_err, b_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // A: 8 regs, no forwarding, normal r0.
  regfile_bypass #(.WIDTH(16), .NREGS(8), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_a (
    .clk(clk), .rst(rst), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .writeRegSel(writeRegSel), .writeData(writeData), .write(write),
    .read1Data(a_rd1), .read2Data(a_rd2), .err(a_err)
  );

  // B: 6 regs, forwarding, zero r0.
  regfile_bypass #(.WIDTH(16), .NREGS(6), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_b (
    .clk(clk), .rst(rst), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .writeRegSel(writeRegSel), .writeData(writeData), .write(write),
    .read1Data(b_rd1), .read2Data(b_rd2), .err(b_err)
  );

  typedef struct {
    string       tag;
    logic [15:0] a1, a2, b1, b2;
    logic        ae, be;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem_a [8];
  logic [15:0] mem_b [6];
  logic        err_a, err_b;

  function automatic logic [15:0] exp_a(input logic [2:0] s);
    return mem_a[s];
  endfunction

  function automatic logic [15:0] exp_b(input logic [2:0] s, input logic w,
                                        input logic [2:0] ws, input logic [15:0] wd);
    if (s == 3'd0 || s >= 3'd6) return 16'h0000;
    if (w && ws == s) return wd;
    return mem_b[s];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic w, input logic [2:0] ws,
                      input logic [15:0] wd, input logic [2:0] s1, input logic [2:0] s2);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; write = w; writeRegSel = ws; writeData = wd;
    read1RegSel = s1; read2RegSel = s2;
    #1;
    e.tag = tag;
    e.a1 = exp_a(s1);            e.a2 = exp_a(s2);
    e.b1 = exp_b(s1, w, ws, wd); e.b2 = exp_b(s2, w, ws, wd);
    e.ae = err_a;                e.be = err_b;
    sb.push_back(e);
    got = sb.pop_front();
    chk({got.tag, ".a_rd1"}, a_rd1, got.a1);
    chk({got.tag, ".a_rd2"}, a_rd2, got.a2);
    chk({got.tag, ".b_rd1"}, b_rd1, got.b1);
    chk({got.tag, ".b_rd2"}, b_rd2, got.b2);
    chk({got.tag, ".a_err"}, {15'd0, a_err}, {15'd0, got.ae});
    chk({got.tag, ".b_err"}, {15'd0, b_err}, {15'd0, got.be});
    $display("step %-10s rst=%0d wr=%0d ws=%0d wd=%h s1=%0d s2=%0d | A %h %h e%0d | B %h %h e%0d",
             tag, r, w, ws, wd, s1, s2, a_rd1, a_rd2, a_err, b_rd1, b_rd2, b_err);
    // Model state after the coming edge.
    if (r) begin
      foreach (mem_a[i]) mem_a[i] = 16'h0;
      foreach (mem_b[i]) mem_b[i] = 16'h0;
      err_a = 1'b0; err_b = 1'b0;
    end else if (w) begin
      mem_a[ws] = wd;
      if (ws >= 3'd6) err_b = 1'b1;
      else if (ws != 3'd0) mem_b[ws] = wd;
    end
  endtask

  initial begin
    foreach (mem_a[i]) mem_a[i] = 16'h0;
    foreach (mem_b[i]) mem_b[i] = 16'h0;
    err_a = 1'b0; err_b = 1'b0;
    rst = 1'b1; write = 1'b0; writeRegSel = '0; writeData = '0;
    read1RegSel = '0; read2RegSel = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) step("rst_read", 0, 0, 0, 16'h0, 3'(i), 3'(7 - i));

    step("wr_beef", 0, 1, 5, 16'hBEEF, 5, 5);
    step("rd_beef", 0, 0, 0, 16'h0,    5, 5);

    step("wr_1111", 0, 1, 3, 16'h1111, 3, 1);
    step("byp_2222", 0, 1, 3, 16'h2222, 3, 3);
    step("rd_2222", 0, 0, 0, 16'h0,    3, 3);

    step("wr_r0",   0, 1, 0, 16'hFFFF, 0, 0);
    step("rd_r0",   0, 0, 0, 16'h0,    0, 3);

    step("oob_wr",  0, 1, 7, 16'hAAAA, 7, 5);
    step("oob_rd",  0, 0, 0, 16'h0,    7, 5);
    for (int i = 0; i < 6; i++) step("oob_keep", 0, 0, 0, 16'h0, 3'(i), 3'(5 - i));

    for (int i = 0; i < 12; i++) begin
      step("rand", 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    step("rst_coll", 1, 1, 2, 16'h1234, 2, 2);
    step("rd_after", 0, 0, 0, 16'h0,    2, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Parametrised register file built around a generalised enable-gated one-hot write decoder. It holds NREGS registers of WIDTH bits, with one synchronous write port and two combinational read ports. It optionally forwards same-cycle write data to the read ports and can hard-wire register 0 to zero. It sits in the decode stage of the pipelined processor, replacing the fixed 8×16 file, and is the block that retires writeback data.

## Interface

- WIDTH, 16: data width of each register and of the read/write data ports.
- NREGS, 8: number of registers; any value ≥ 2, not required to be a power of two.
- ADDR_W, $clog2(NREGS): width of every register-select port; derived, not overridden.
- BYPASS, 1: 1 = a read of the register being written this cycle returns writeData; 0 = it returns the stored value.
- ZERO_R0, 0: 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- read1RegSel  input  ADDR_W  register select for read port 1.
- read2RegSel  input  ADDR_W  register select for read port 2.
- writeRegSel  input  ADDR_W  register select for the write port.
- writeData  input  WIDTH  data to write.
- write  input  1  write enable.
- read1Data  output  WIDTH  combinational read data, port 1.
- read2Data  output  WIDTH  combinational read data, port 2.
- err  output  1  registered sticky error flag.

## Operation

- Write decode: the decoder_n instance turns writeRegSel and write into an NREGS-bit one-hot enable vector. All bits are 0 when write = 0 or writeRegSel ≥ NREGS.
- Register update: on a rising clk edge with rst = 0, the register whose enable bit is 1 loads writeData. All other registers hold.
- ZERO_R0 = 1: enable bit 0 is forced to 0, and reads of select 0 return 0 regardless of BYPASS.
- Reads: readNData = register[readNRegSel]. A select ≥ NREGS returns 0.
- Bypass (BYPASS = 1): if write = 1, writeRegSel < NREGS, and readNRegSel == writeRegSel (and the select is not a zero-forced r0), then readNData = writeData in the same cycle. Each port is evaluated independently, so both ports may bypass at once.
- err: set on the edge after any cycle with write = 1 and writeRegSel ≥ NREGS. Once set it stays 1 until rst. No register changes in the offending cycle.
- Reset: when rst = 1 at an edge, every register becomes 0 and err becomes 0. A write in the same cycle as rst is discarded (reset has priority).
- Reset mid-operation: bypass is combinational, so it still forwards writeData during a cycle in which rst = 1. The stored value after that edge is 0.

## Timing

- Write latency: 1 edge. Data presented in cycle n is readable from stored state in cycle n+1.
- Read latency: 0 (combinational from the select inputs, and from writeData/write when bypassing).
- err: asserts one edge after the offending request; it has no combinational path from inputs.
- Reset values: all registers 0; err 0; read outputs are therefore 0 for in-range selects until the first write.
- Back-to-back writes to the same register: the last one wins. Each is visible through the bypass in its own cycle.

## Structure

- Shared package regfile_pkg holds the default WIDTH and NREGS and a function computing ADDR_W.
- Sub-module decoder_n has parameters N and AW and ports Addr[AW-1:0], We, Out[N-1:0]. It is a generalised successor to the 3-to-8 enable-gated decoder. Out is 0 for Addr ≥ N.
- The storage array and read multiplexers are written inline in regfile_bypass. Each read port has its own multiplexer.

## Test plan

- Reset and read: hold rst = 1 for 2 cycles, then release. Reading every select returns 0x0000 and err = 0.
- Basic write/read: write 0xBEEF to r5 in cycle 1 with write = 1 and BYPASS = 0. read1 of r5 in cycle 1 returns 0x0000; in cycle 2 it returns 0xBEEF.
- Bypass: BYPASS = 1, r3 = 0x1111, write 0x2222 to r3 while both read ports select r3. Both ports return 0x2222 in that same cycle; on the next cycle, with write = 0, both return 0x2222.
- Zero register: ZERO_R0 = 1, write 0xFFFF to r0 with BYPASS = 1. read1Data returns 0x0000 in that cycle and the next.
- Out-of-range select: NREGS = 6, write 0xAAAA with writeRegSel = 7. err = 1 from the next edge onward, registers r0 to r5 are unchanged, and reading select 7 returns 0. err clears only after rst.
- Reset collision: write 0x1234 to r2 with rst = 1 in the same cycle. The next cycle, r2 reads 0x0000.
